// File: rtl/i2s_pkg.sv
// Shared types and sizing helpers for the I2S stream transmitter.
// Imported by the FIFO and the transmitter top.
package i2s_pkg;

    typedef enum logic {
        I2S_PHILIPS   = 1'b0,
        I2S_LEFT_JUST = 1'b1
    } i2s_mode_e;

    function automatic int frame_bits(input int slot_w);
        return 2 * slot_w;
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous stereo-pair FIFO with occupancy level.
// Power-of-two depth lets the pointers wrap naturally.
module sample_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic [level_w(DEPTH)-1:0]   level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == LW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q];
    assign level   = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/i2s_tx_stream.sv
// I2S / left-justified transmitter: SCLK/LRCLK divider, frame
// shifter and sticky underrun flag fed from a sample-pair FIFO.
module i2s_tx_stream
    import i2s_pkg::*;
#(
    parameter int        SAMPLE_W   = 16,
    parameter int        SLOT_W     = 32,
    parameter int        CLK_DIV    = 2,
    parameter int        FIFO_DEPTH = 4,
    parameter i2s_mode_e MODE       = I2S_PHILIPS
) (
    input  logic                             Clk,
    input  logic                             RESET_N,
    input  logic                             EN,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [SAMPLE_W-1:0]              s_left,
    input  logic [SAMPLE_W-1:0]              s_right,
    input  logic                             underrun_clr,
    output logic                             SCLK,
    output logic                             LRCLK,
    output logic                             I2S_Dout,
    output logic                             underrun,
    output logic [level_w(FIFO_DEPTH)-1:0]   fifo_level
);

    localparam int FW  = frame_bits(SLOT_W);
    localparam int KW  = $clog2(FW);
    localparam int DW  = $clog2(CLK_DIV + 1);
    localparam int PAD = SLOT_W - SAMPLE_W;

    if (SAMPLE_W > SLOT_W || FIFO_DEPTH < 2 || CLK_DIV < 1 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("i2s_tx_stream: unsupported parameter set");
    end

    logic                  en_q;
    logic [DW-1:0]         div_q;
    logic [KW-1:0]         k_q, k_d;
    logic [FW-1:0]         sh_q;
    logic                  sclk_q, lr_q, dout_q, urun_q;

    logic                  full, empty;
    logic [2*SAMPLE_W-1:0] rdata;
    logic [SLOT_W-1:0]     lslot, rslot;
    logic [FW-1:0]         frame_d;
    logic                  start, tick, fall, wrap, load;

    assign start = EN && !en_q;
    assign tick  = (div_q == DW'(CLK_DIV - 1));
    assign fall  = EN && tick && sclk_q;
    assign wrap  = fall && (k_q == KW'(FW - 1));
    assign load  = start || wrap;
    assign k_d   = k_q + 1'b1;

    // Samples sit left-aligned in their slot; the pad below is zero.
    assign lslot   = SLOT_W'(rdata[2*SAMPLE_W-1:SAMPLE_W]) << PAD;
    assign rslot   = SLOT_W'(rdata[SAMPLE_W-1:0]) << PAD;
    assign frame_d = empty ? '0 : {lslot, rslot};

    sample_fifo #(
        .WIDTH (2 * SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (RESET_N),
        .push  (s_valid),
        .wdata ({s_left, s_right}),
        .pop   (load),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge Clk or negedge RESET_N) begin
        if (!RESET_N) begin
            en_q   <= 1'b0;
            div_q  <= '0;
            k_q    <= '0;
            sh_q   <= '0;
            sclk_q <= 1'b0;
            lr_q   <= 1'b0;
            dout_q <= 1'b0;
            urun_q <= 1'b0;
        end else begin
            en_q <= EN;
            if (load && empty)  urun_q <= 1'b1;
            else if (underrun_clr) urun_q <= 1'b0;
            if (!EN) begin
                div_q  <= '0;
                k_q    <= '0;
                sh_q   <= '0;
                sclk_q <= 1'b0;
                lr_q   <= 1'b0;
                dout_q <= 1'b0;
            end else begin
                div_q <= tick ? '0 : div_q + 1'b1;
                if (tick) sclk_q <= !sclk_q;
                if (load) begin
                    k_q  <= '0;
                    lr_q <= 1'b0;
                    // Philips shows the held-back last bit of the old frame first.
                    if (MODE == I2S_LEFT_JUST) begin
                        dout_q <= frame_d[FW-1];
                        sh_q   <= frame_d << 1;
                    end else begin
                        dout_q <= sh_q[FW-1];
                        sh_q   <= frame_d;
                    end
                end else if (fall) begin
                    k_q    <= k_d;
                    lr_q   <= (k_d >= KW'(SLOT_W));
                    dout_q <= sh_q[FW-1];
                    sh_q   <= sh_q << 1;
                end
            end
        end
    end

    assign s_ready  = !full;
    assign SCLK     = sclk_q;
    assign LRCLK    = lr_q;
    assign I2S_Dout = dout_q;
    assign underrun = urun_q;

endmodule
